universal_logic_pipe: RTL
=========================

Name: universal_logic_pipe

Overview:
Parametrised, pipelined successor to the 1-bit NAND/NOR gate block. It applies one of eight bitwise logic operations, selected per transaction, to two WIDTH-bit operands. Operands and results move through valid/ready handshakes, and each result carries zero and parity flags. The block sits between an operand producer and a result consumer in the logic-gates library, and also keeps a running count of completed results.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of completed-transaction counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select (see Behaviour)
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result beat
y  output  WIDTH  result
zero  output  1  1 when y == 0
parity  output  1  XOR-reduction of y
done_cnt  output  CNT_W  number of result beats transferred since reset

Behaviour:
- One clock (clk) only. Reset is asynchronous, active-low (rst_n); assertion takes effect immediately, release is synchronous to clk.
- Op encoding: 0 NAND ~(a&b); 1 NOR ~(a|b); 2 AND; 3 OR; 4 XOR; 5 XNOR; 6 NOT a (b ignored); 7 PASS a. All codes are legal.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Two register stages:
  - S1 captures a, b, op and s1_valid.
  - S2 holds the computed y, zero, parity and s2_valid (out_valid = s2_valid).
  - Result and flags are computed combinationally from S1 and registered into S2.
- Advance logic:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational path from out_ready is allowed)
- Latency: a beat accepted at edge N presents out_valid at edge N+2 if not stalled. Throughput is 1 beat/cycle under continuous out_ready.
- Backpressure: while out_valid && !out_ready, y/zero/parity/out_valid hold stable. S1 may still fill once, after which in_ready = 0. No beat is dropped or duplicated.
- Bubbles collapse: an empty S2 accepts from S1 regardless of out_ready.
- A producer may drop in_valid without a transfer. Inputs are sampled only on a transfer.
- done_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0 with no flag.
- Reset values:
  - in_ready, out_valid, y, zero, parity, done_cnt: 0.
  - Internal s1_valid, s2_valid: 0.
  - zero resets to 0 even though y resets to 0. zero is only meaningful while out_valid = 1.
  - in_ready goes to 1 on the first cycle after reset release.
- Reset mid-operation: all in-flight beats are discarded and done_cnt clears. After release no stale beat appears on the output.
- Simultaneous input and output transfer in the same cycle with S1 and S2 both full: S1 moves to S2, the new beat enters S1, and the count updates by exactly 1.

Decomposition:
- Package universal_logic_pkg holds:
  - Op encoding constants OP_NAND..OP_PASS (3-bit).
  - A typedef for the op field.
  - A pure function logic_op(a, b, op) returning WIDTH bits, written behaviourally as a case on op.
- One natural sub-module: universal_logic_core. It is purely combinational: a, b, op in; y, zero, parity out. It is instantiated between S1 and S2 and reused by the bench as the reference model.

Test Plan:
1. WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, ops 0..7 back-to-back -> y = 3F, 03, C0, FC, 3C, C3, 0F, F0 on 8 consecutive cycles, first at 2 cycles after first accept. Parity is 0 for every one of these results. done_cnt=8.
2. op=2, a=8'hAA, b=8'h55 -> y=00, zero=1, parity=0. op=3, a=8'h01, b=8'h00 -> y=01, zero=0, parity=1.
3. Backpressure: stream 4 beats, hold out_ready=0 for 5 cycles -> in_ready falls after 2 beats are held; y stays stable. Releasing out_ready delivers all 4 beats in order with no loss.
4. Random in_valid/out_ready toggling, 1000 beats, compared against universal_logic_core model -> exact in-order match; done_cnt=1000 mod 2^CNT_W.
5. CNT_W=2, 5 transfers -> done_cnt sequence 1, 2, 3, 0, 1.
6. Assert rst_n low with both stages full -> out_valid, done_cnt and y go 0 immediately. After release there is no output until a new beat is accepted, which then arrives 2 cycles later.

Source files
------------

// File: rtl/universal_logic_pkg.sv
// Shared op encoding and the behavioural logic-operation function for the
// universal logic pipe.
`default_nettype none

package universal_logic_pkg;

   // Widest operand the shared function handles; callers slice their width.
   localparam int LOGIC_MAX_W = 64;

   typedef logic [2:0] op_t;

   localparam op_t OP_NAND = 3'd0;
   localparam op_t OP_NOR  = 3'd1;
   localparam op_t OP_AND  = 3'd2;
   localparam op_t OP_OR   = 3'd3;
   localparam op_t OP_XOR  = 3'd4;
   localparam op_t OP_XNOR = 3'd5;
   localparam op_t OP_NOT  = 3'd6;
   localparam op_t OP_PASS = 3'd7;

   function automatic logic [LOGIC_MAX_W-1:0] logic_op(
      input logic [LOGIC_MAX_W-1:0] a,
      input logic [LOGIC_MAX_W-1:0] b,
      input op_t                    op
   );
      logic [LOGIC_MAX_W-1:0] r;
      case (op)
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         OP_NOT:  r = ~a;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/universal_logic_core.sv
// Combinational bitwise operation with zero and parity flags.
`default_nettype none

module universal_logic_core
   import universal_logic_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity
);

   logic [LOGIC_MAX_W-1:0] a_ext;
   logic [LOGIC_MAX_W-1:0] b_ext;
   logic [LOGIC_MAX_W-1:0] y_ext;

   always_comb begin
      a_ext            = '0;
      b_ext            = '0;
      a_ext[WIDTH-1:0] = a;
      b_ext[WIDTH-1:0] = b;
   end

   assign y_ext  = logic_op(a_ext, b_ext, op);
   assign y      = y_ext[WIDTH-1:0];
   assign zero   = (y == '0);
   assign parity = ^y;

   // Bits above WIDTH carry inverted zero-padding and are deliberately dropped.
   generate
      if (WIDTH < LOGIC_MAX_W) begin : g_hi_drop
         logic unused_hi;
         assign unused_hi = ^y_ext[LOGIC_MAX_W-1:WIDTH];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/universal_logic_pipe.sv
// Two-stage valid/ready pipeline applying a selectable bitwise operation,
// with result flags and a completed-transfer counter.
`default_nettype none

module universal_logic_pipe
   import universal_logic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] done_cnt
);

   logic             active;
   logic             s1_valid;
   logic             s2_valid;
   logic             s1_adv;
   logic             s2_adv;
   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   op_t              s1_op;
   logic [WIDTH-1:0] core_y;
   logic             core_zero;
   logic             core_parity;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   // Held low through the first edge after release so in_ready reads 0 in reset.
   assign in_ready  = active && s1_adv;
   assign in_xfer   = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign out_xfer  = s2_valid && out_ready;

   universal_logic_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .y      (core_y),
      .zero   (core_zero),
      .parity (core_parity)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active   <= 1'b0;
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_NAND;
         s2_valid <= 1'b0;
         y        <= '0;
         zero     <= 1'b0;
         parity   <= 1'b0;
         done_cnt <= '0;
      end else begin
         active <= 1'b1;
         if (s1_adv) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
               s1_a  <= a;
               s1_b  <= b;
               s1_op <= op;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               y      <= core_y;
               zero   <= core_zero;
               parity <= core_parity;
            end
         end
         if (out_xfer) begin
            done_cnt <= done_cnt + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire
